// File: rtl/reg_file_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_sb : 32x32 register file with a pending-write scoreboard and stall.
// Option macro: REGFILE_BYPASS_EN (writeback forwarding to reads and hazards).
// Revision 1.0
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter logic [31:0] SP_INIT = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  output logic        stall_o
);

  logic [31:0] regs_q [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        rs_haz;
  logic        rt_haz;
  logic        wr_valid;

  assign wr_valid = wr_en_i && (wr_addr_i != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? SP_INIT : 32'd0;
      end
    end else if (wr_valid) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : regs_q[rt_addr_i];
    if (wr_valid && (wr_addr_i == rs_addr_i)) rs_data_o = wr_data_i;
    if (wr_valid && (wr_addr_i == rt_addr_i)) rt_data_o = wr_data_i;
  end

  // A register whose producer is writing back right now is already satisfied.
  assign rs_haz = busy_q[rs_addr_i] && (rs_addr_i != 5'd0) &&
                  !(wr_en_i && (wr_addr_i == rs_addr_i));
  assign rt_haz = busy_q[rt_addr_i] && (rt_addr_i != 5'd0) &&
                  !(wr_en_i && (wr_addr_i == rt_addr_i));
`else
  always_comb begin
    rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : regs_q[rt_addr_i];
  end

  assign rs_haz = busy_q[rs_addr_i] && (rs_addr_i != 5'd0);
  assign rt_haz = busy_q[rt_addr_i] && (rt_addr_i != 5'd0);
`endif

  assign stall_o = issue_i && (rs_haz || rt_haz);

  // Set is applied after clear so a new producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (issue_i && !stall_o && (issue_rd_i != 5'd0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= 32'd0;
    else       busy_q <= busy_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// tb_reg_file_sb : table-driven reset reads plus hand sequences for write,
// scoreboard set/clear, stall and reset-override behaviour.
module tb_reg_file_sb;

  localparam logic [31:0] SP = 32'h0000_0080;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, issue_rd;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        wr_en, issue, stall;

  reg_file_sb #(.SP_INIT(SP)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rs_data_o(rs_data), .rt_data_o(rt_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_i(issue), .issue_rd_i(issue_rd), .stall_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[32];
  int   tests;
  int   fails;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Inputs are already driven; queue the expectation then sample away from the edge.
  task automatic probe(input string name, input logic [31:0] e_rs,
                       input logic [31:0] e_rt, input logic e_stall);
    exp_t e;
    sb_q.push_back('{name, e_rs, e_rt, e_stall});
    #1;
    e = sb_q.pop_front();
    cmp({e.name, ".rs"}, rs_data, e.rs);
    cmp({e.name, ".rt"}, rt_data, e.rt);
    cmp({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    issue = 1'b0; issue_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) begin
      vecs[i].rs     = 5'(i);
      vecs[i].rt     = 5'(31 - i);
      vecs[i].exp_rs = (i == 29) ? SP : 32'd0;
      vecs[i].exp_rt = ((31 - i) == 29) ? SP : 32'd0;
    end

    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    rs_addr = 5'd29; rt_addr = 5'd0;
    probe("in_reset", SP, 32'd0, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 32; i++) begin
      rs_addr = vecs[i].rs;
      rt_addr = vecs[i].rt;
      probe($sformatf("reset_read%0d", i), vecs[i].exp_rs, vecs[i].exp_rt, 1'b0);
    end

    // Writes, including a discarded write to r0.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    rs_addr = 5'd5; rt_addr = 5'd0;
`ifdef REGFILE_BYPASS_EN
    probe("wr5_same_cycle", 32'hDEAD_BEEF, 32'd0, 1'b0);
`else
    probe("wr5_same_cycle", 32'd0, 32'd0, 1'b0);
`endif
    step();
    wr_addr = 5'd0; wr_data = 32'h0000_1234;
    step();
    idle();
    rs_addr = 5'd5; rt_addr = 5'd0;
    probe("wr_read", 32'hDEAD_BEEF, 32'd0, 1'b0);

    // RAW hazard on r8 held until writeback.
    issue = 1'b1; issue_rd = 5'd8;
    rs_addr = 5'd0; rt_addr = 5'd0;
    probe("issue_rd8", 32'd0, 32'd0, 1'b0);
    step();
    issue_rd = 5'd0; rs_addr = 5'd8;
    probe("raw8_a", 32'd0, 32'd0, 1'b1);
    step();
    probe("raw8_b", 32'd0, 32'd0, 1'b1);
    step();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
    probe("raw8_wb", 32'h55, 32'd0, 1'b0);
`else
    probe("raw8_wb", 32'd0, 32'd0, 1'b1);
`endif
    step();
    wr_en = 1'b0;
    probe("raw8_after", 32'h55, 32'd0, 1'b0);
    step();

    // Clear and set of r9 in the same cycle: set wins.
    idle();
    issue = 1'b1; issue_rd = 5'd9;
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    probe("clrset9", 32'd0, 32'd0, 1'b0);
    step();
    idle();
    issue = 1'b1; rs_addr = 5'd9;
    probe("clrset9_reader", 32'h99, 32'd0, 1'b1);
    step();
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    step();

    // Stalled issue (rt hazard on r11) must not mark r10 busy.
    idle();
    issue = 1'b1; issue_rd = 5'd11;
    step();
    issue_rd = 5'd10; rt_addr = 5'd11;
    probe("stall_rt11", 32'd0, 32'd0, 1'b1);
    step();
    idle();
    issue = 1'b1; rs_addr = 5'd10; rt_addr = 5'd9;
    probe("no_busy10", 32'd0, 32'h99, 1'b0);
    step();

    // Reset overrides a write and clears the scoreboard.
    idle();
    issue = 1'b1; issue_rd = 5'd8;
    step();
    issue_rd = 5'd0; rs_addr = 5'd8;
    probe("busy8_set", 32'h55, 32'd0, 1'b1);
    idle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h77;
    issue = 1'b1; issue_rd = 5'd8;
    step();
    rst = 1'b0;
    idle();
    issue = 1'b1; rs_addr = 5'd8; rt_addr = 5'd29;
    probe("post_rst_r8", 32'd0, SP, 1'b0);
    rs_addr = 5'd11; rt_addr = 5'd9;
    probe("post_rst_busy", 32'd0, 32'd0, 1'b0);
    rs_addr = 5'd5; rt_addr = 5'd10;
    probe("post_rst_r5", 32'd0, 32'd0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
